tlp_rx_pkt_buf: RTL and testbench

- Store-and-forward packet buffer directly upstream of the PCIe-to-AXI master's requester TLP input (req_tlp_*).
- Accepts request TLP beats from the link-layer receive path, checks sop/eop framing, and drops malformed or oversized packets.
- Presents only complete, well-framed packets downstream, so the TLP demux and write/read converters never see a truncated TLP.

---
 rtl/tlp_rx_pkt_buf.sv | 217 +++++++++++++++++++++
 tb/tb_tlp_rx_pkt_buf.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_rx_pkt_buf.sv
// -----------------------------------------------------------------------------
// tlp_rx_pkt_buf
// Store-and-forward buffer for request TLPs ahead of the PCIe-to-AXI master.
// Beats from the link-layer receive path are written into a circular array.
// They become visible downstream only after the eop beat is accepted.
// Malformed packets (sop/eop violations) and packets too large for the array
// are discarded, so the consumer only ever sees complete, well-framed TLPs.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_*            upstream beat interface (hdr/data/strb/sop/eop/valid/ready)
//   out_*           downstream beat interface toward req_tlp_*
//   pkt_count       complete packets held
//   beat_count      occupied entries, committed plus in-progress
//   framing_err     one-cycle pulse on a sop/eop violation
//   drop_pkt        one-cycle pulse when an oversize packet is discarded
// -----------------------------------------------------------------------------
module tlp_rx_pkt_buf #(
  parameter int DOUBLE_WORD    = 32,
  parameter int HEADER_SIZE    = 4*DOUBLE_WORD,
  parameter int TLP_DATA_WIDTH = 8*DOUBLE_WORD,
  parameter int TLP_STRB_WIDTH = TLP_DATA_WIDTH/8,
  parameter int DEPTH          = 16,
  parameter int CNT_WIDTH      = $clog2(DEPTH)+1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [HEADER_SIZE-1:0]    in_hdr,
  input  logic [TLP_DATA_WIDTH-1:0] in_data,
  input  logic [TLP_STRB_WIDTH-1:0] in_strb,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [HEADER_SIZE-1:0]    out_hdr,
  output logic [TLP_DATA_WIDTH-1:0] out_data,
  output logic [TLP_STRB_WIDTH-1:0] out_strb,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_WIDTH-1:0]      pkt_count,
  output logic [CNT_WIDTH-1:0]      beat_count,
  output logic                      framing_err,
  output logic                      drop_pkt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef struct packed {
    logic [HEADER_SIZE-1:0]    hdr;
    logic [TLP_DATA_WIDTH-1:0] data;
    logic [TLP_STRB_WIDTH-1:0] strb;
    logic                      sop;
    logic                      eop;
  } entry_t;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_IN_PKT = 2'd1, ST_DROP = 2'd2} state_e;

  entry_t               mem_q [DEPTH];
  entry_t               rd_entry_s;
  state_e               state_q, state_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, commit_ptr_q, commit_ptr_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic                 framing_err_q, framing_err_d, drop_pkt_q, drop_pkt_d;
  logic [PW-1:0]        occ_s;
  logic                 full_s, accept_s, read_s, read_eop_s, oversize_s;
  logic                 wr_en_s, commit_s;
  logic [AW-1:0]        wr_addr_s;

  // Pointers span 2*DEPTH so full and empty stay distinguishable.
  assign occ_s      = wr_ptr_q - rd_ptr_q;
  assign full_s     = (occ_s == PW'(DEPTH));
  assign in_ready   = !rst && ((state_q == ST_DROP) || !full_s);
  assign accept_s   = in_valid && in_ready;
  assign out_valid  = (rd_ptr_q != commit_ptr_q);
  assign read_s     = out_valid && out_ready;
  assign rd_entry_s = mem_q[rd_ptr_q[AW-1:0]];
  assign read_eop_s = read_s && rd_entry_s.eop;
  // Packet fills the array while nothing committed is ahead of it: it can never complete.
  assign oversize_s = (state_q == ST_IN_PKT) && full_s && (commit_ptr_q == rd_ptr_q);

  assign out_hdr     = rd_entry_s.hdr;
  assign out_data    = rd_entry_s.data;
  assign out_strb    = rd_entry_s.strb;
  assign out_sop     = rd_entry_s.sop;
  assign out_eop     = rd_entry_s.eop;
  assign pkt_count   = pkt_count_q;
  assign beat_count  = CNT_WIDTH'(occ_s);
  assign framing_err = framing_err_q;
  assign drop_pkt    = drop_pkt_q;

  // Write FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Write FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && in_sop)   state_d = in_eop ? ST_IDLE : ST_IN_PKT;
        else if (accept_s)        state_d = in_eop ? ST_IDLE : ST_DROP;
        else                      state_d = ST_IDLE;
      end
      ST_IN_PKT: begin
        if (oversize_s)               state_d = ST_DROP;
        else if (accept_s && in_eop)  state_d = ST_IDLE;
        else                          state_d = ST_IN_PKT;
      end
      ST_DROP: begin
        if (accept_s && in_eop) state_d = ST_IDLE;
        else                    state_d = ST_DROP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write FSM outputs: array write, write/commit pointer moves, error pulses.
  always_comb begin
    wr_en_s       = 1'b0;
    wr_addr_s     = wr_ptr_q[AW-1:0];
    wr_ptr_d      = wr_ptr_q;
    commit_ptr_d  = commit_ptr_q;
    commit_s      = 1'b0;
    framing_err_d = 1'b0;
    drop_pkt_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && in_sop) begin
          wr_en_s  = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (in_eop) begin
            commit_ptr_d = wr_ptr_q + PTR_ONE;
            commit_s     = 1'b1;
          end else begin
            commit_s = 1'b0;
          end
        end else if (accept_s) begin
          framing_err_d = 1'b1;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_IN_PKT: begin
        if (oversize_s) begin
          wr_ptr_d   = commit_ptr_q;
          drop_pkt_d = 1'b1;
        end else if (accept_s && in_sop) begin
          // Abandon the partial packet; the new sop restarts at the commit point.
          framing_err_d = 1'b1;
          wr_en_s       = 1'b1;
          wr_addr_s     = commit_ptr_q[AW-1:0];
          wr_ptr_d      = commit_ptr_q + PTR_ONE;
          if (in_eop) begin
            commit_ptr_d = commit_ptr_q + PTR_ONE;
            commit_s     = 1'b1;
          end else begin
            commit_s = 1'b0;
          end
        end else if (accept_s) begin
          wr_en_s  = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (in_eop) begin
            commit_ptr_d = wr_ptr_q + PTR_ONE;
            commit_s     = 1'b1;
          end else begin
            commit_s = 1'b0;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_DROP: wr_en_s = 1'b0;
      default: wr_en_s = 1'b0;
    endcase
  end

  // Read pointer and packet counter next state.
  always_comb begin
    rd_ptr_d = read_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({commit_s, read_eop_s})
      2'b10:   pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
      2'b01:   pkt_count_d = pkt_count_q - CNT_WIDTH'(1);
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  // Pointer, counter and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      commit_ptr_q  <= '0;
      pkt_count_q   <= '0;
      framing_err_q <= 1'b0;
      drop_pkt_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      commit_ptr_q  <= commit_ptr_d;
      pkt_count_q   <= pkt_count_d;
      framing_err_q <= framing_err_d;
      drop_pkt_q    <= drop_pkt_d;
    end
  end

  // Beat storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_q[wr_addr_s] <= {in_hdr, in_data, in_strb, in_sop, in_eop};
  end

endmodule

// File: tb/tb_tlp_rx_pkt_buf.sv
module tb_tlp_rx_pkt_buf;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_hdr;
  logic [255:0] in_data;
  logic [31:0]  in_strb;
  logic         in_sop, in_eop, in_valid, in_ready;
  logic [127:0] out_hdr;
  logic [255:0] out_data;
  logic [31:0]  out_strb;
  logic         out_sop, out_eop, out_valid, out_ready;
  logic [4:0]   pkt_count, beat_count;
  logic         framing_err, drop_pkt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlp_rx_pkt_buf dut (
    .clk(clk), .rst(rst),
    .in_hdr(in_hdr), .in_data(in_data), .in_strb(in_strb),
    .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid), .in_ready(in_ready),
    .out_hdr(out_hdr), .out_data(out_data), .out_strb(out_strb),
    .out_sop(out_sop), .out_eop(out_eop), .out_valid(out_valid), .out_ready(out_ready),
    .pkt_count(pkt_count), .beat_count(beat_count),
    .framing_err(framing_err), .drop_pkt(drop_pkt)
  );

  function automatic logic [127:0] mk_hdr(input logic [31:0] t);
    return {4{t ^ 32'h5A5A0000}};
  endfunction
  function automatic logic [255:0] mk_data(input logic [31:0] t);
    return {8{t}};
  endfunction
  function automatic logic [31:0] mk_strb(input logic [31:0] t);
    return {4{t[7:0]}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit sop, input bit eop, input bit ordy, input logic [31:0] tag);
    in_valid  = v;
    in_sop    = sop;
    in_eop    = eop;
    out_ready = ordy;
    in_hdr    = mk_hdr(tag);
    in_data   = mk_data(tag);
    in_strb   = mk_strb(tag);
  endtask

  task automatic check_outputs(input string nm, input bit irdy, input bit ov, input logic [31:0] otag,
                               input bit osop, input bit oeop, input int pkt, input int beat,
                               input bit fe, input bit dp);
    chk({nm, ".in_ready"}, in_ready, irdy);
    chk({nm, ".out_valid"}, out_valid, ov);
    chk({nm, ".pkt_count"}, pkt_count, pkt);
    chk({nm, ".beat_count"}, beat_count, beat);
    chk({nm, ".framing_err"}, framing_err, fe);
    chk({nm, ".drop_pkt"}, drop_pkt, dp);
    if (ov && out_valid) begin
      chk({nm, ".out_data"}, out_data, mk_data(otag));
      chk({nm, ".out_hdr"}, out_hdr, mk_hdr(otag));
      chk({nm, ".out_strb"}, out_strb, mk_strb(otag));
      chk({nm, ".out_sop"}, out_sop, osop);
      chk({nm, ".out_eop"}, out_eop, oeop);
    end
  endtask

  // Directed vector table: inputs for one cycle and the outputs expected before that edge.
  typedef struct {
    bit v; bit sop; bit eop; bit ordy; logic [31:0] tag;
    bit irdy; bit ov; logic [31:0] otag; bit osop; bit oeop;
    int pkt; int beat; bit fe; bit dp;
  } vec_t;

  // Behavioural reference: committed beats waiting for output, and the packet being built.
  typedef struct { logic [31:0] tag; bit sop; bit eop; } beat_t;
  beat_t cq[$];
  beat_t pq[$];
  int    m_mode;   // 0 idle, 1 building a packet, 2 discarding to eop
  bit    m_fe, m_dp;

  function automatic int m_pkts();
    int n = 0;
    foreach (cq[i]) if (cq[i].eop) n++;
    return n;
  endfunction

  task automatic model_step(input bit v, input bit sop, input bit eop, input bit ordy, input logic [31:0] tag);
    int    occ   = cq.size() + pq.size();
    bit    full  = (occ == DEPTH);
    bit    irdy  = (m_mode == 2) || !full;
    bit    acc   = v && irdy;
    int    cpre  = cq.size();
    beat_t b;
    b.tag = tag; b.sop = sop; b.eop = eop;
    m_fe = 0; m_dp = 0;
    if (cpre > 0 && ordy) void'(cq.pop_front());
    if (m_mode == 0) begin
      if (acc && sop) begin
        pq.push_back(b);
        if (eop) begin cq = {cq, pq}; pq.delete(); end
        else m_mode = 1;
      end else if (acc) begin
        m_fe = 1;
        m_mode = eop ? 0 : 2;
      end
    end else if (m_mode == 1) begin
      if (full && cpre == 0) begin
        pq.delete(); m_dp = 1; m_mode = 2;
      end else if (acc) begin
        if (sop) begin m_fe = 1; pq.delete(); end
        pq.push_back(b);
        if (eop) begin cq = {cq, pq}; pq.delete(); m_mode = 0; end
      end
    end else begin
      if (acc && eop) m_mode = 0;
    end
  endtask

  initial begin
    vec_t tbl[$];
    int   pre;
    logic [31:0] tg;
    bit   v, s, e, r;

    drive(0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    #2;
    check_outputs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // 3-beat packet with out_ready high
    tbl.push_back('{1,1,0,1,32'hA0, 1,0,0,0,0, 0,0,0,0});
    tbl.push_back('{1,0,0,1,32'hA1, 1,0,0,0,0, 0,1,0,0});
    tbl.push_back('{1,0,1,1,32'hA2, 1,0,0,0,0, 0,2,0,0});
    tbl.push_back('{0,0,0,1,32'h0,  1,1,32'hA0,1,0, 1,3,0,0});
    tbl.push_back('{0,0,0,1,32'h0,  1,1,32'hA1,0,0, 1,2,0,0});
    tbl.push_back('{0,0,0,1,32'h0,  1,1,32'hA2,0,1, 1,1,0,0});
    tbl.push_back('{0,0,0,1,32'h0,  1,0,0,0,0, 0,0,0,0});
    // two single-beat packets held back, then released
    tbl.push_back('{1,1,1,0,32'hB0, 1,0,0,0,0, 0,0,0,0});
    tbl.push_back('{1,1,1,0,32'hB1, 1,1,32'hB0,1,1, 1,1,0,0});
    tbl.push_back('{0,0,0,0,32'h0,  1,1,32'hB0,1,1, 2,2,0,0});
    tbl.push_back('{0,0,0,1,32'h0,  1,1,32'hB0,1,1, 2,2,0,0});
    tbl.push_back('{0,0,0,1,32'h0,  1,1,32'hB1,1,1, 1,1,0,0});
    tbl.push_back('{0,0,0,1,32'h0,  1,0,0,0,0, 0,0,0,0});
    // partial packet C interrupted by sop of D
    tbl.push_back('{1,1,0,1,32'hC0, 1,0,0,0,0, 0,0,0,0});
    tbl.push_back('{1,0,0,1,32'hC1, 1,0,0,0,0, 0,1,0,0});
    tbl.push_back('{1,1,0,1,32'hD0, 1,0,0,0,0, 0,2,0,0});
    tbl.push_back('{1,0,1,1,32'hD1, 1,0,0,0,0, 0,1,1,0});
    tbl.push_back('{0,0,0,1,32'h0,  1,1,32'hD0,1,0, 1,2,0,0});
    tbl.push_back('{0,0,0,1,32'h0,  1,1,32'hD1,0,1, 1,1,0,0});
    tbl.push_back('{0,0,0,1,32'h0,  1,0,0,0,0, 0,0,0,0});
    // beat without sop in idle, then discard through eop (inner sop is silent)
    tbl.push_back('{1,0,0,1,32'hE0, 1,0,0,0,0, 0,0,0,0});
    tbl.push_back('{1,1,0,1,32'hE1, 1,0,0,0,0, 0,0,1,0});
    tbl.push_back('{1,0,1,1,32'hE2, 1,0,0,0,0, 0,0,0,0});
    tbl.push_back('{0,0,0,1,32'h0,  1,0,0,0,0, 0,0,0,0});
    tbl.push_back('{1,1,1,1,32'hF0, 1,0,0,0,0, 0,0,0,0});
    tbl.push_back('{0,0,0,1,32'h0,  1,1,32'hF0,1,1, 1,1,0,0});
    tbl.push_back('{0,0,0,1,32'h0,  1,0,0,0,0, 0,0,0,0});

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].sop, tbl[i].eop, tbl[i].ordy, tbl[i].tag);
      #1;
      check_outputs($sformatf("vec%0d", i), tbl[i].irdy, tbl[i].ov, tbl[i].otag,
                    tbl[i].osop, tbl[i].oeop, tbl[i].pkt, tbl[i].beat, tbl[i].fe, tbl[i].dp);
    end

    // Oversize: 20-beat packet into an empty buffer
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); drive(1, i == 0, 0, 1, 32'h100 + 32'(i)); #1;
      check_outputs($sformatf("ovs_fill%0d", i), 1, 0, 0, 0, 0, 0, i, 0, 0);
    end
    @(negedge clk); drive(1, 0, 0, 1, 32'h110); #1;
    check_outputs("ovs_full", 0, 0, 0, 0, 0, 0, 16, 0, 0);
    for (int i = 17; i <= 20; i++) begin
      @(negedge clk); drive(1, 0, i == 20, 1, 32'h100 + 32'(i)); #1;
      check_outputs($sformatf("ovs_drop%0d", i), 1, 0, 0, 0, 0, 0, 0, 0, i == 17);
    end
    @(negedge clk); drive(0, 0, 0, 1, 32'h0); #1;
    check_outputs("ovs_end", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 1, 1, 1, 32'h200); #1;
    check_outputs("ovs_next_in", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 1, 32'h0); #1;
    check_outputs("ovs_next_out", 1, 1, 32'h200, 1, 1, 1, 1, 0, 0);
    @(negedge clk); #1;
    check_outputs("ovs_next_done", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-packet: one committed 2-beat packet plus 3 uncommitted beats
    @(negedge clk); drive(1, 1, 0, 0, 32'h300); #1;
    check_outputs("rst_b0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 1, 0, 32'h301); #1;
    check_outputs("rst_b1", 1, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 2; i < 5; i++) begin
      @(negedge clk); drive(1, i == 2, 0, 0, 32'h300 + 32'(i)); #1;
      check_outputs($sformatf("rst_b%0d", i), 1, 1, 32'h300, 1, 0, 1, i, 0, 0);
    end
    @(negedge clk); drive(0, 0, 0, 0, 32'h0); #1;
    check_outputs("rst_pre", 1, 1, 32'h300, 1, 0, 1, 5, 0, 0);
    rst = 1'b1; #1;
    check_outputs("rst_async", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    check_outputs("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk); drive(1, 1, 1, 1, 32'h400); #1;
    check_outputs("rst_after_in", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 1, 32'h0); #1;
    check_outputs("rst_after_out", 1, 1, 32'h400, 1, 1, 1, 1, 0, 0);

    // Randomized traffic against the reference model
    @(negedge clk); rst = 1'b1; drive(0, 0, 0, 0, 32'h0);
    @(negedge clk); rst = 1'b0;
    cq.delete(); pq.delete(); m_mode = 0; m_fe = 0; m_dp = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      v  = ($urandom_range(9, 0) < 7);
      s  = ($urandom_range(3, 0) == 0);
      e  = (n < 2000) ? ($urandom_range(2, 0) == 0) : ($urandom_range(11, 0) == 0);
      r  = ((n % 300) < 100) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
      tg = $urandom();
      drive(v, s, e, r, tg);
      #1;
      pre = cq.size() + pq.size();
      check_outputs($sformatf("rnd%0d", n), (m_mode == 2) || (pre != DEPTH), cq.size() > 0,
                    (cq.size() > 0) ? cq[0].tag : 32'h0, (cq.size() > 0) ? cq[0].sop : 1'b0,
                    (cq.size() > 0) ? cq[0].eop : 1'b0, m_pkts(), pre, m_fe, m_dp);
      model_step(v, s, e, r, tg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
